// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the EX-stage branch resolution logic: instruction kinds,
// branch funct3 values and the redirect/flush FSM states.
package riscv_branch_defines;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_JALR   = 2'd3
  } kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational branch condition: funct3 plus ALU z/n flags -> taken.
// Odd funct3 values are the inverted sense of their even partner.
module branch_cond
  import riscv_branch_defines::*;
(
  input  logic [2:0] funct3_i,
  input  logic       z_i,
  input  logic       n_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ, F3_BNE:                   taken_o = z_i ^ funct3_i[0];
      F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: taken_o = n_i ^ funct3_i[0];
      default:                          taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: taken decision, target mux, registered
// PC-redirect handshake with multi-cycle flush, and saturating perf counters.
module branch_resolve
  import riscv_branch_defines::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid_i,
  input  logic             ex_stall_i,
  input  logic [1:0]       ex_kind_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_imm_i,
  input  logic             z_alu_i,
  input  logic             n_alu_i,
  input  logic [31:0]      res_alu_i,
  input  logic             redirect_ready_i,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam int unsigned DW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = (FLUSH_DEPTH > 0) ? DW'(FLUSH_DEPTH - 1) : '0;

  kind_e             kind;
  logic              cond_taken;
  logic              resolve;
  logic              is_branch;
  logic              taken;
  logic [31:0]       target;
  logic              aligned;
  logic              unused_res_lsb;

  state_e            state_q,          state_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [31:0]       redirect_pc_q,    redirect_pc_d;
  logic              flush_q,          flush_d;
  logic              misalign_q,       misalign_d;
  logic [DW-1:0]     drain_cnt_q,      drain_cnt_d;
  logic [CNT_W-1:0]  branch_cnt_q,     branch_cnt_d;
  logic [CNT_W-1:0]  taken_cnt_q,      taken_cnt_d;

  assign kind           = kind_e'(ex_kind_i);
  assign unused_res_lsb = res_alu_i[0];

  branch_cond u_cond (
    .funct3_i (ex_funct3_i),
    .z_i      (z_alu_i),
    .n_i      (n_alu_i),
    .taken_o  (cond_taken)
  );

  // Anything presented outside IDLE is wrong-path and must not touch state.
  always_comb begin
    resolve   = ex_valid_i && !ex_stall_i && (kind != KIND_NONE) && (state_q == ST_IDLE);
    is_branch = (kind == KIND_BRANCH);
    taken     = resolve && (!is_branch || cond_taken);
    target    = (kind == KIND_JALR) ? {res_alu_i[31:1], 1'b0} : (ex_pc_i + ex_imm_i);
    aligned   = is_word_aligned(target);
  end

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    drain_cnt_d      = drain_cnt_q;
    misalign_d       = taken && !aligned;

    case (state_q)
      ST_IDLE: begin
        if (taken && aligned) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
          flush_d          = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready_i) begin
          redirect_valid_d = 1'b0;
          if (FLUSH_DEPTH == 0) begin
            state_d = ST_IDLE;
            flush_d = 1'b0;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_IDLE;
          flush_d = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      default: begin
        state_d          = ST_IDLE;
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
        drain_cnt_d      = '0;
      end
    endcase
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (resolve && is_branch && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (taken && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      misalign_q       <= 1'b0;
      drain_cnt_q      <= '0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      misalign_q       <= misalign_d;
      drain_cnt_q      <= drain_cnt_d;
      branch_cnt_q     <= branch_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_o          = flush_q;
  assign misalign_o       = misalign_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign branch_cnt_o     = branch_cnt_q;
  assign taken_cnt_o      = taken_cnt_q;

endmodule
